// File: rtl/psg_multi.sv
// psg_multi: parametrised AY-style sound generator (1..8 tone channels, shared noise/envelope).
// Define PSG_MULTI_STEREO_EN for left/right enable masks (0x26/0x27) and snd_l/snd_r outputs.
module psg_multi #(
  parameter int CHANNELS = 3,
  parameter int TW       = 12,
  parameter int PRESC    = 16,
  parameter int EPRESC   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clk_en,
  input  logic [5:0]                      addr,
  input  logic                            wr,
  input  logic [7:0]                      din,
  output logic [7:0]                      dout,
  output logic [8*CHANNELS-1:0]           ch_lvl,
`ifdef PSG_MULTI_STEREO_EN
  output logic [8+$clog2(CHANNELS+1)-1:0] snd_l,
  output logic [8+$clog2(CHANNELS+1)-1:0] snd_r,
`endif
  output logic [8+$clog2(CHANNELS+1)-1:0] snd
);
  localparam int SW = 8 + $clog2(CHANNELS + 1);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int EW = (EPRESC > 1) ? $clog2(EPRESC) : 1;

  logic [TW-1:0]       period  [CHANNELS];
  logic [15:0]         per_ext [CHANNELS];
  logic [TW-1:0]       per_m1  [CHANNELS];
  logic [TW-1:0]       tcnt    [CHANNELS];
  logic [3:0]          vol     [CHANNELS];
  logic [CHANNELS-1:0] use_env, tdis, ndis, tone, ch_hit;
  logic [4:0]          noise_per, ncnt, nper_m1;
  logic [15:0]         env_per, env_cnt, eper_m1;
  logic [3:0]          env_shape, env_step, env_lvl;
  logic                env_inv, env_hold, env_restart;
  logic [16:0]         lfsr;
  logic [PW-1:0]       presc_cnt;
  logic [EW-1:0]       env_div;
  logic                tick, env_wrap;
  logic [7:0]          rdata;
  logic [8*CHANNELS-1:0] lvl_d;
  logic [SW-1:0]       sum_d;
`ifdef PSG_MULTI_STEREO_EN
  logic [CHANNELS-1:0] lmask, rmask;
  logic [SW-1:0]       sum_l, sum_r;
`endif

  function automatic logic [7:0] lut(input logic [3:0] i);
    case (i)
      4'd0:  lut = 8'd0;    4'd1:  lut = 8'd2;    4'd2:  lut = 8'd3;    4'd3:  lut = 8'd4;
      4'd4:  lut = 8'd6;    4'd5:  lut = 8'd8;    4'd6:  lut = 8'd11;   4'd7:  lut = 8'd16;
      4'd8:  lut = 8'd23;   4'd9:  lut = 8'd32;   4'd10: lut = 8'd45;   4'd11: lut = 8'd64;
      4'd12: lut = 8'd90;   4'd13: lut = 8'd128;  4'd14: lut = 8'd181;  default: lut = 8'd255;
    endcase
  endfunction

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      ch_hit[n]  = !addr[5] && (addr[4:2] == 3'(n));
      per_ext[n] = 16'(period[n]);
      per_m1[n]  = (period[n] == '0) ? '0 : period[n] - 1'b1;
    end
  end

  assign nper_m1     = (noise_per == 5'd0) ? 5'd0 : noise_per - 5'd1;
  assign eper_m1     = (env_per == 16'd0) ? 16'd0 : env_per - 16'd1;
  assign env_restart = wr && (addr == 6'h25);
  assign tick        = clk_en && (presc_cnt == PW'(PRESC - 1));
  assign env_wrap    = (env_div == EW'(EPRESC - 1));
  assign env_lvl     = (env_shape[2] ^ env_inv) ? env_step : ~env_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        period[n] <= '0;
        vol[n]    <= '0;
      end
      use_env   <= '0;
      tdis      <= '0;
      ndis      <= '0;
      noise_per <= '0;
      env_per   <= '0;
      env_shape <= '0;
`ifdef PSG_MULTI_STEREO_EN
      lmask     <= '1;
      rmask     <= '1;
`endif
    end else if (wr) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_hit[n]) begin
          case (addr[1:0])
            2'd0: period[n] <= TW'({per_ext[n][15:8], din});
            2'd1: period[n] <= TW'({din, per_ext[n][7:0]});
            2'd2: begin
              vol[n]     <= din[3:0];
              use_env[n] <= din[4];
            end
            default: ;
          endcase
        end
      end
      case (addr)
        6'h20: noise_per      <= din[4:0];
        6'h21: tdis           <= din[CHANNELS-1:0];
        6'h22: ndis           <= din[CHANNELS-1:0];
        6'h23: env_per[7:0]   <= din;
        6'h24: env_per[15:8]  <= din;
        6'h25: env_shape      <= din[3:0];
`ifdef PSG_MULTI_STEREO_EN
        6'h26: lmask          <= din[CHANNELS-1:0];
        6'h27: rmask          <= din[CHANNELS-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'd0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (ch_hit[n]) begin
        case (addr[1:0])
          2'd0:    rdata = per_ext[n][7:0];
          2'd1:    rdata = per_ext[n][15:8];
          2'd2:    rdata = {3'b000, use_env[n], vol[n]};
          default: rdata = 8'd0;
        endcase
      end
    end
    case (addr)
      6'h20: rdata = {3'b000, noise_per};
      6'h21: rdata = 8'(tdis);
      6'h22: rdata = 8'(ndis);
      6'h23: rdata = env_per[7:0];
      6'h24: rdata = env_per[15:8];
      6'h25: rdata = {4'b0000, env_shape};
`ifdef PSG_MULTI_STEREO_EN
      6'h26: rdata = 8'(lmask);
      6'h27: rdata = 8'(rmask);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 8'd0;
    else        dout <= rdata;
  end

  // Tone and noise counters use >= so a shrunken period fires on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      for (int n = 0; n < CHANNELS; n++) tcnt[n] <= '0;
      tone <= '0;
      ncnt <= '0;
      lfsr <= 17'h1;
    end else if (clk_en) begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (tcnt[n] >= per_m1[n]) begin
            tcnt[n] <= '0;
            tone[n] <= ~tone[n];
          end else begin
            tcnt[n] <= tcnt[n] + 1'b1;
          end
        end
        if (ncnt >= nper_m1) begin
          ncnt <= 5'd0;
          lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ncnt <= ncnt + 5'd1;
        end
      end
    end
  end

  // A shape write restarts the envelope and takes priority over a divider expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_div  <= '0;
      env_cnt  <= '0;
      env_step <= '0;
      env_inv  <= 1'b0;
      env_hold <= 1'b0;
    end else if (env_restart) begin
      env_div  <= '0;
      env_cnt  <= '0;
      env_step <= '0;
      env_inv  <= 1'b0;
      env_hold <= 1'b0;
    end else if (tick) begin
      env_div <= env_wrap ? '0 : env_div + 1'b1;
      if (env_wrap) begin
        if (env_cnt >= eper_m1) begin
          env_cnt <= '0;
          if (!env_hold) begin
            if (env_step != 4'hF) begin
              env_step <= env_step + 4'd1;
            end else if (!env_shape[3]) begin
              env_hold <= 1'b1;
              env_inv  <= env_shape[2];
            end else if (env_shape[0]) begin
              env_hold <= 1'b1;
              env_inv  <= env_inv ^ env_shape[1];
            end else begin
              env_step <= 4'd0;
              if (env_shape[1]) env_inv <= ~env_inv;
            end
          end
        end else begin
          env_cnt <= env_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    lvl_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if ((tone[n] | tdis[n]) & (lfsr[0] | ndis[n]))
        lvl_d[8*n +: 8] = lut(use_env[n] ? env_lvl : vol[n]);
    end
  end

  always_comb begin
    sum_d = '0;
`ifdef PSG_MULTI_STEREO_EN
    sum_l = '0;
    sum_r = '0;
`endif
    for (int n = 0; n < CHANNELS; n++) begin
      sum_d = sum_d + SW'(ch_lvl[8*n +: 8]);
`ifdef PSG_MULTI_STEREO_EN
      if (lmask[n]) sum_l = sum_l + SW'(ch_lvl[8*n +: 8]);
      if (rmask[n]) sum_r = sum_r + SW'(ch_lvl[8*n +: 8]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_lvl <= '0;
      snd    <= '0;
`ifdef PSG_MULTI_STEREO_EN
      snd_l  <= '0;
      snd_r  <= '0;
`endif
    end else if (clk_en) begin
      ch_lvl <= lvl_d;
      snd    <= sum_d;
`ifdef PSG_MULTI_STEREO_EN
      snd_l  <= sum_l;
      snd_r  <= sum_r;
`endif
    end
  end

endmodule

// File: tb/tb_psg_multi.sv
// Self-checking bench for psg_multi: register table, tone, period edge cases, envelope, noise.
`timescale 1ns/1ps
module tb_psg_multi;
  localparam int CH = 3;
  localparam int SW = 8 + $clog2(CH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic [5:0]    addr = '0;
  logic          wr = 1'b0;
  logic [7:0]    din = '0;
  logic [7:0]    dout;
  logic [8*CH-1:0] ch_lvl;
  logic [SW-1:0] snd;
`ifdef PSG_MULTI_STEREO_EN
  logic [SW-1:0] snd_l, snd_r;
`endif

  psg_multi #(.CHANNELS(CH), .TW(12), .PRESC(16), .EPRESC(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .addr(addr), .wr(wr), .din(din),
    .dout(dout), .ch_lvl(ch_lvl),
`ifdef PSG_MULTI_STEREO_EN
    .snd_l(snd_l), .snd_r(snd_r),
`endif
    .snd(snd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] exp_q [$];
  logic [7:0]  lut_m [16];
  int          compared = 0;
  int          mismatched = 0;
  int          ecount = 0;
  logic [16:0] lfsr_m;
  logic [31:0] hold_v;

  task automatic cyc();
    @(posedge clk);
    if (clk_en) ecount++;
    @(negedge clk);
  endtask

  task automatic runTo(input int target);
    clk_en = 1'b1;
    while (ecount < target) cyc();
  endtask

  task automatic wrReg(input logic [5:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    cyc();
    wr   = 1'b0;
  endtask

  task automatic doReset();
    clk_en = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    din    = '0;
    rst_n  = 1'b0;
    cyc();
    cyc();
    rst_n  = 1'b1;
    cyc();
    ecount = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] expv);
    exp_q.push_back(expv);
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act);
    logic [31:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h but no expected value queued", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", nm, act, e, ecount);
      end
    end
  endtask

  function automatic int toneAt(input int j, input int per);
    if (j <= 0) return 0;
    return ((j / 16) / per) % 2;
  endfunction

  function automatic int triStep(input int s);
    if (((s / 16) % 2) == 0) return s % 16;
    return 15 - (s % 16);
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    lut_m = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
              8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd181, 8'd255};
    vecs[0]  = '{6'h00, 8'hA5, 8'hA5};
    vecs[1]  = '{6'h01, 8'hFF, 8'h0F};
    vecs[2]  = '{6'h02, 8'hFF, 8'h1F};
    vecs[3]  = '{6'h03, 8'hFF, 8'h00};
    vecs[4]  = '{6'h09, 8'h3C, 8'h0C};
    vecs[5]  = '{6'h0C, 8'h55, 8'h00};
    vecs[6]  = '{6'h20, 8'hFF, 8'h1F};
    vecs[7]  = '{6'h21, 8'hFF, 8'h07};
    vecs[8]  = '{6'h22, 8'hFA, 8'h02};
    vecs[9]  = '{6'h23, 8'h34, 8'h34};
    vecs[10] = '{6'h24, 8'h12, 8'h12};
    vecs[11] = '{6'h25, 8'hFF, 8'h0F};
`ifdef PSG_MULTI_STEREO_EN
    vecs[12] = '{6'h26, 8'hFD, 8'h05};
`else
    vecs[12] = '{6'h26, 8'hFD, 8'h00};
`endif
    vecs[13] = '{6'h30, 8'hFF, 8'h00};

    // Reset state and every address reading zero
    doReset();
    applyStimulus(32'd0); checkOutput("reset_dout", 32'(dout));
    applyStimulus(32'd0); checkOutput("reset_ch_lvl", 32'(ch_lvl));
    applyStimulus(32'd0); checkOutput("reset_snd", 32'(snd));
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      applyStimulus(32'd0);
      cyc();
      checkOutput("reset_read", 32'(dout));
    end

    // Register table: writes with clk_en low, read back one clock later
    for (int i = 0; i < 14; i++) begin
      wrReg(vecs[i].a, vecs[i].wd);
      applyStimulus(32'(vecs[i].rd));
      cyc();
      checkOutput("reg_readback", 32'(dout));
    end

    // Tone on ch0, period 4: toggles every 4 ticks (64 clk)
    doReset();
    wrReg(6'h00, 8'd4);
    wrReg(6'h02, 8'h0F);
    wrReg(6'h21, 8'h06);
    wrReg(6'h22, 8'h07);
    clk_en = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(toneAt(k - 1, 4) != 0 ? 32'd255 : 32'd0);
      applyStimulus(toneAt(k - 2, 4) != 0 ? 32'd255 : 32'd0);
      cyc();
      checkOutput("tone_ch_lvl", 32'(ch_lvl));
      checkOutput("tone_snd", 32'(snd));
    end

    // Period 0 and period 1 on ch1 both toggle every tick
    for (int p = 0; p < 2; p++) begin
      doReset();
      wrReg(6'h04, 8'(p));
      wrReg(6'h06, 8'h0F);
      wrReg(6'h21, 8'h05);
      wrReg(6'h22, 8'h07);
      clk_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
        applyStimulus(toneAt(k - 1, 1) != 0 ? 32'h0000FF00 : 32'd0);
        cyc();
        checkOutput(p == 0 ? "per0_ch_lvl" : "per1_ch_lvl", 32'(ch_lvl));
      end
    end

    // Shrinking the period below the running count fires on the next tick
    doReset();
    wrReg(6'h00, 8'd100);
    wrReg(6'h02, 8'h0F);
    wrReg(6'h21, 8'h06);
    wrReg(6'h22, 8'h07);
    runTo(80);
    clk_en = 1'b0;
    wrReg(6'h00, 8'd2);
    runTo(95);
    applyStimulus(32'd0);   checkOutput("shrink_before", 32'(ch_lvl));
    runTo(97);
    applyStimulus(32'd255); checkOutput("shrink_after", 32'(ch_lvl));
    runTo(98);
    applyStimulus(32'd255); checkOutput("shrink_snd", 32'(snd));

    // Envelope triangle (shape 0xE), one step per 256 clk
    doReset();
    wrReg(6'h02, 8'h10);
    wrReg(6'h21, 8'h07);
    wrReg(6'h22, 8'h07);
    wrReg(6'h23, 8'h01);
    wrReg(6'h25, 8'h0E);
    for (int s = 0; s <= 40; s++) begin
      applyStimulus(32'(lut_m[triStep(s)]));
      applyStimulus(32'(lut_m[triStep(s)]));
      runTo(256 * s + 128);
      checkOutput("env_ch_lvl", 32'(ch_lvl));
      checkOutput("env_snd", 32'(snd));
    end

    // Envelope restart coinciding with a divider expiry
    doReset();
    wrReg(6'h02, 8'h10);
    wrReg(6'h21, 8'h07);
    wrReg(6'h22, 8'h07);
    wrReg(6'h23, 8'h01);
    wrReg(6'h25, 8'h0D);
    runTo(1023);
    applyStimulus(32'd4); checkOutput("restart_pre", 32'(ch_lvl));
    addr = 6'h25;
    din  = 8'h0D;
    wr   = 1'b1;
    cyc();
    wr   = 1'b0;
    applyStimulus(32'd4); checkOutput("restart_edge", 32'(ch_lvl));
    cyc();
    applyStimulus(32'd0); checkOutput("restart_next", 32'(ch_lvl));
    runTo(1200);
    applyStimulus(32'd0); checkOutput("restart_hold0", 32'(ch_lvl));
    runTo(1290);
    applyStimulus(32'd2); checkOutput("restart_step1", 32'(ch_lvl));

    // Noise only, period 0: one LFSR shift per tick, freeze midway
    doReset();
    wrReg(6'h02, 8'h0F);
    wrReg(6'h21, 8'h07);
    wrReg(6'h22, 8'h06);
    wrReg(6'h20, 8'h00);
    lfsr_m = 17'h1;
    for (int t = 1; t <= 100; t++) begin
      lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
      hold_v = lfsr_m[0] ? 32'd255 : 32'd0;
      applyStimulus(hold_v);
      applyStimulus(hold_v);
      runTo(16 * t + 2);
      checkOutput("noise_ch_lvl", 32'(ch_lvl));
      checkOutput("noise_snd", 32'(snd));
      if (t == 50) begin
        clk_en = 1'b0;
        repeat (50) cyc();
        applyStimulus(hold_v); checkOutput("freeze_ch_lvl", 32'(ch_lvl));
        applyStimulus(hold_v); checkOutput("freeze_snd", 32'(snd));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
